// File: rtl/llr_loader.sv
// llr_loader: saturates streamed channel LLRs and writes them one per cell via a one-hot strobe.
module llr_loader #(
  parameter int D_WID   = 8,
  parameter int IN_WID  = 10,
  parameter int N_CELL  = 16,
  parameter int CNT_WID = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [IN_WID-1:0] llr_in,
  input  logic              llr_valid,
  output logic              llr_ready,
  output logic [D_WID-1:0]  din,
  output logic [N_CELL-1:0] sin,
  output logic              busy,
  output logic              load_done,
  output logic              sat_flag
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic signed [IN_WID-1:0] PMAX = IN_WID'(2 ** (D_WID - 1) - 1);
  localparam logic signed [IN_WID-1:0] NMAX = -PMAX;
  state_t state;
  logic [CNT_WID-1:0] cnt;
  logic signed [IN_WID-1:0] llr_s;
  logic hi, lo;
  logic [D_WID-1:0] sat_val;
  assign llr_s = llr_in;
  assign hi = llr_s > PMAX;
  assign lo = llr_s < NMAX;
  // symmetric clip: the most negative code is never produced
  assign sat_val = hi ? PMAX[D_WID-1:0] : lo ? NMAX[D_WID-1:0] : llr_in[D_WID-1:0];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      din       <= '0;
      sin       <= '0;
      llr_ready <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      sin       <= '0;
      load_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= LOAD;
          cnt       <= '0;
          sat_flag  <= 1'b0;
          busy      <= 1'b1;
          llr_ready <= 1'b1;
        end
        LOAD: if (llr_valid && llr_ready) begin
          din <= sat_val;
          sin <= N_CELL'(1) << cnt;
          if (hi || lo) sat_flag <= 1'b1;
          if (cnt == CNT_WID'(N_CELL - 1)) begin
            state     <= DONE;
            llr_ready <= 1'b0;
            load_done <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
